// File: rtl/esn_sat_accum_frame.sv
// Multi-channel saturating up/down accumulator that publishes per-frame channel sums.
// Optional feature: define ESN_SAT_ACCUM_LEAK_EN to carry a shifted sum into the next frame.
module esn_sat_accum_frame #(
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned CH         = 2,
   parameter int unsigned STEP_W     = 2,
   parameter int unsigned FRAME_LEN  = 4,
   parameter int unsigned CNT_W      = $clog2(FRAME_LEN + 1),
   parameter int unsigned LEAK_SHIFT = 1
) (
   input  logic                     iClk,
   input  logic                     iRst_n,
   input  logic                     iClear,
   input  logic                     iValid,
   output logic                     oReady,
   input  logic [CH-1:0]            iBitU,
   input  logic [STEP_W-1:0]        iStep,
   output logic                     oValid,
   input  logic                     iReady,
   output logic [CH*DATA_W-1:0]     oSum,
   output logic [CH-1:0]            oSatFlag,
   output logic [CNT_W-1:0]         oTermCnt
);

   localparam int MaxVal = 2 ** (DATA_W - 1) - 1;
   localparam logic signed [DATA_W:0] MaxX = (DATA_W + 1)'(MaxVal);
   localparam logic signed [DATA_W:0] MinX = -MaxX;
   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(FRAME_LEN - 1);

   typedef enum logic [0:0] {StAcc, StOut} state_e;

   state_e state_q, state_d;

   logic [CH-1:0][DATA_W-1:0] acc_q, acc_d;
   logic [CH-1:0][DATA_W-1:0] sum_q, sum_d;
   logic [CH-1:0][DATA_W-1:0] sum_nx;
   logic [CH-1:0][DATA_W-1:0] restart;
   logic [CH-1:0]             sat_q, sat_d;
   logic [CH-1:0]             sat_hi, sat_lo;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      valid_q, valid_d;
   logic                      accept;
   logic                      last_term;
   logic                      handshake;
   logic signed [DATA_W:0]    step_x;

   assign step_x    = $signed({{(DATA_W + 1 - STEP_W){1'b0}}, iStep});
   assign accept    = iValid && oReady;
   assign last_term = (cnt_q == LastCnt);
   assign handshake = (state_q == StOut) && iReady;

   // One guard bit keeps acc +/- step exact before clamping.
   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic signed [DATA_W:0] ext;
      logic signed [DATA_W:0] raw;

      assign ext       = $signed({acc_q[c][DATA_W-1], acc_q[c]});
      assign raw       = iBitU[c] ? (ext + step_x) : (ext - step_x);
      assign sat_hi[c] = (raw > MaxX);
      assign sat_lo[c] = (raw < MinX);
      assign sum_nx[c] = sat_hi[c] ? MaxX[DATA_W-1:0] :
                         sat_lo[c] ? MinX[DATA_W-1:0] : raw[DATA_W-1:0];

`ifdef ESN_SAT_ACCUM_LEAK_EN
      assign restart[c] = $signed(sum_q[c]) >>> LEAK_SHIFT;
`else
      assign restart[c] = '0;
`endif
   end

   // State register
   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state_q <= StAcc;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      if (iClear) begin
         state_d = StAcc;
      end else begin
         unique case (state_q)
            StAcc: if (accept && last_term) state_d = StOut;
            StOut: if (iReady)              state_d = StAcc;
            default:                        state_d = StAcc;
         endcase
      end
   end

   // Output logic
   always_comb begin
      oReady = (state_q == StAcc);
   end

   always_comb begin
      acc_d   = acc_q;
      sum_d   = sum_q;
      sat_d   = sat_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      if (iClear) begin
         acc_d   = '0;
         sat_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end else if (accept) begin
         acc_d = sum_nx;
         sat_d = sat_q | sat_hi | sat_lo;
         cnt_d = cnt_q + 1'b1;
         if (last_term) begin
            sum_d   = sum_nx;
            valid_d = 1'b1;
         end
      end else if (handshake) begin
         acc_d   = restart;
         sat_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         acc_q   <= '0;
         sum_q   <= '0;
         sat_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         sat_q   <= sat_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign oSum     = sum_q;
   assign oSatFlag = sat_q;
   assign oTermCnt = cnt_q;
   assign oValid   = valid_q;

endmodule

// File: tb/tb_esn_sat_accum_frame.sv
// Scoreboard bench for esn_sat_accum_frame: a behavioural model queues expected frames.
module tb_esn_sat_accum_frame;

   localparam int DW = 4;
   localparam int NC = 2;
   localparam int SW = 2;
   localparam int FL = 4;
   localparam int CW = $clog2(FL + 1);
   localparam int MaxV = 7;

   logic           iClk = 1'b0;
   logic           iRst_n;
   logic           iClear;
   logic           iValid;
   logic           oReady;
   logic [NC-1:0]  iBitU;
   logic [SW-1:0]  iStep;
   logic           oValid;
   logic           iReady;
   logic [NC*DW-1:0] oSum;
   logic [NC-1:0]  oSatFlag;
   logic [CW-1:0]  oTermCnt;

   typedef struct {
      int         s0;
      int         s1;
      logic [1:0] sat;
   } exp_t;

   exp_t exp_q[$];
   int   macc[NC];
   logic [1:0] msat;
   int   mcnt;
   int   last_sum[NC];
   int   n_checks = 0;
   int   n_fail = 0;

   esn_sat_accum_frame #(
      .DATA_W(DW), .CH(NC), .STEP_W(SW), .FRAME_LEN(FL), .CNT_W(CW), .LEAK_SHIFT(1)
   ) u_dut (
      .iClk    (iClk),
      .iRst_n  (iRst_n),
      .iClear  (iClear),
      .iValid  (iValid),
      .oReady  (oReady),
      .iBitU   (iBitU),
      .iStep   (iStep),
      .oValid  (oValid),
      .iReady  (iReady),
      .oSum    (oSum),
      .oSatFlag(oSatFlag),
      .oTermCnt(oTermCnt)
   );

   always #5 iClk = ~iClk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int ch_sum(input int c);
      logic signed [DW-1:0] v;
      v = oSum[c*DW +: DW];
      return int'(v);
   endfunction

   task automatic model_reset();
      for (int c = 0; c < NC; c++) macc[c] = 0;
      msat = '0;
      mcnt = 0;
   endtask

   task automatic model_accept(input logic [1:0] b, input int s);
      for (int c = 0; c < NC; c++) begin
         int v;
         v = macc[c] + (b[c] ? s : -s);
         if (v > MaxV) begin
            v = MaxV;
            msat[c] = 1'b1;
         end else if (v < -MaxV) begin
            v = -MaxV;
            msat[c] = 1'b1;
         end
         macc[c] = v;
      end
      mcnt++;
      if (mcnt == FL) exp_q.push_back('{s0: macc[0], s1: macc[1], sat: msat});
   endtask

   task automatic send_term(input logic [1:0] b, input int s, input logic clr);
      iValid = 1'b1;
      iBitU  = b;
      iStep  = s[SW-1:0];
      iClear = clr;
      @(posedge iClk);
      #1;
      iValid = 1'b0;
      iClear = 1'b0;
      if (clr) model_reset();
      else model_accept(b, s);
      check("term_cnt", oTermCnt, mcnt);
      check("valid_latency", oValid, (mcnt == FL));
   endtask

   task automatic send_frame(input logic [1:0] b, input int s);
      for (int i = 0; i < FL; i++) send_term(b, s, 1'b0);
   endtask

   task automatic collect();
      int n;
      exp_t e;
      n = 0;
      while (oValid !== 1'b1 && n < 20) begin
         @(posedge iClk);
         #1;
         n++;
      end
      if (oValid !== 1'b1) begin
         check("valid_timeout", oValid, 1);
         return;
      end
      if (exp_q.size() == 0) begin
         check("queue_empty", 0, 1);
         return;
      end
      e = exp_q.pop_front();
      check("sum_ch0", ch_sum(0), e.s0);
      check("sum_ch1", ch_sum(1), e.s1);
      check("sat_flag", oSatFlag, e.sat);
      check("ready_in_out", oReady, 0);
      last_sum[0] = e.s0;
      last_sum[1] = e.s1;
   endtask

   task automatic handshake();
      iReady = 1'b1;
      @(posedge iClk);
      #1;
      iReady = 1'b0;
      check("hs_valid", oValid, 0);
      check("hs_cnt", oTermCnt, 0);
      check("hs_sat", oSatFlag, 0);
      check("hs_ready", oReady, 1);
      check("hs_sum_hold", ch_sum(0), last_sum[0]);
`ifdef ESN_SAT_ACCUM_LEAK_EN
      for (int c = 0; c < NC; c++) macc[c] = last_sum[c] >>> 1;
`else
      for (int c = 0; c < NC; c++) macc[c] = 0;
`endif
      msat = '0;
      mcnt = 0;
   endtask

   initial begin
      iRst_n = 1'b0;
      iClear = 1'b0;
      iValid = 1'b0;
      iBitU  = '0;
      iStep  = '0;
      iReady = 1'b0;
      model_reset();
      last_sum[0] = 0;
      last_sum[1] = 0;
      #12;
      check("rst_sum", oSum, 0);
      check("rst_valid", oValid, 0);
      check("rst_sat", oSatFlag, 0);
      check("rst_cnt", oTermCnt, 0);
      check("rst_ready", oReady, 1);
      iRst_n = 1'b1;
      @(posedge iClk);
      #1;

      // Small steps, no clamping
      send_frame(2'b01, 1);
      collect();
      handshake();

      // Large steps clamp both channels, then backpressure
      send_frame(2'b01, 3);
      collect();
      for (int i = 0; i < 5; i++) begin
         iValid = 1'b1;
         iBitU  = 2'b11;
         iStep  = 2'd3;
         @(posedge iClk);
         #1;
         check("bp_valid", oValid, 1);
         check("bp_ready", oReady, 0);
         check("bp_cnt", oTermCnt, FL);
         check("bp_sum", ch_sum(0), last_sum[0]);
         check("bp_sat", oSatFlag, msat);
      end
      iValid = 1'b0;
      handshake();
      send_frame(2'b01, 1);
      collect();
      handshake();

      // Clear mid-frame drops the concurrent term
      send_term(2'b01, 1, 1'b0);
      send_term(2'b01, 1, 1'b0);
      send_term(2'b01, 1, 1'b1);
      send_frame(2'b01, 1);
      collect();
      handshake();

      // Exact hits of MAX/MIN and a zero step do not flag
      send_term(2'b01, 3, 1'b0);
      send_term(2'b01, 3, 1'b0);
      send_term(2'b01, 1, 1'b0);
      send_term(2'b10, 0, 1'b0);
      collect();
      handshake();

      // Random frames
      for (int f = 0; f < 4; f++) begin
         for (int i = 0; i < FL; i++)
            send_term(2'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
         collect();
         handshake();
      end

      // Clear while holding a finished frame
      send_frame(2'b10, 2);
      collect();
      iClear = 1'b1;
      @(posedge iClk);
      #1;
      iClear = 1'b0;
      model_reset();
      check("clr_out_valid", oValid, 0);
      check("clr_out_ready", oReady, 1);
      check("clr_out_sat", oSatFlag, 0);
      check("clr_out_sum_hold", ch_sum(1), last_sum[1]);

      // Asynchronous reset mid-frame
      send_term(2'b11, 2, 1'b0);
      send_term(2'b11, 2, 1'b0);
      iRst_n = 1'b0;
      #2;
      check("amid_cnt", oTermCnt, 0);
      check("amid_sum", oSum, 0);
      check("amid_ready", oReady, 1);
      iRst_n = 1'b1;
      model_reset();
      last_sum[0] = 0;
      last_sum[1] = 0;
      @(posedge iClk);
      #1;
      send_frame(2'b11, 1);
      collect();
      handshake();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
